// File: rtl/counter_seq_checker.sv
// Purpose: receive-side monitor for a modulo-MODULUS free-running counter. It locks onto the sequence,
//          flags breaks and wraps, and keeps saturating error/wrap statistics.
// Latency: 1 cycle. Every output is registered, so a sample taken at edge N shows up after edge N.
// Backpressure: none. The block samples q_in whenever q_valid=1 and never stalls the source.
// Ports: clk, reset (async active-low), q_in/q_valid (sample), clear (sync stats clear),
//        locked, err_pulse, wrap_pulse, expected, err_count, wrap_count.
module counter_seq_checker #(
  parameter int WIDTH      = 10,
  parameter int MODULUS    = 1000,
  parameter int LOCK_COUNT = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] q_in,
  input  logic             q_valid,
  input  logic             clear,
  output logic             locked,
  output logic             err_pulse,
  output logic             wrap_pulse,
  output logic [WIDTH-1:0] expected,
  output logic [CNT_W-1:0] err_count,
  output logic [CNT_W-1:0] wrap_count
);

  typedef enum logic [1:0] {S_UNLOCKED, S_TRAIN, S_LOCKED} state_t;

  localparam logic [WIDTH-1:0] MAX_V     = WIDTH'(MODULUS - 1);
  localparam logic [WIDTH:0]   MOD_V     = (WIDTH + 1)'(MODULUS);
  localparam logic [3:0]       LOCK_CNT4 = 4'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

  state_t           state;
  logic [3:0]       good;
  logic             in_range;
  logic             match;
  logic [WIDTH-1:0] nxt;
  logic             do_err;
  logic             do_wrap;

  always_comb begin
    in_range = ({1'b0, q_in} < MOD_V);
    match    = q_valid && in_range && (q_in == expected);
    nxt      = (q_in == MAX_V) ? '0 : q_in + WIDTH'(1);
    // Errors and wraps only exist while locked; training never pulses.
    do_err   = q_valid && (state == S_LOCKED) && !match;
    do_wrap  = (state == S_LOCKED) && match && (q_in == MAX_V);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_UNLOCKED;
      good       <= '0;
      locked     <= 1'b0;
      err_pulse  <= 1'b0;
      wrap_pulse <= 1'b0;
      expected   <= '0;
      err_count  <= '0;
      wrap_count <= '0;
    end else begin
      err_pulse  <= do_err;
      wrap_pulse <= do_wrap;

      // Clear wins over a same-cycle increment; the pulses still fire.
      if (clear) begin
        err_count  <= '0;
        wrap_count <= '0;
      end else begin
        if (do_err && err_count != CNT_MAX)   err_count  <= err_count + CNT_W'(1);
        if (do_wrap && wrap_count != CNT_MAX) wrap_count <= wrap_count + CNT_W'(1);
      end

      if (q_valid) begin
        unique case (state)
          S_UNLOCKED: begin
            // Out-of-range samples never seed the expectation.
            if (in_range) begin
              expected <= nxt;
              good     <= 4'd1;
              if (LOCK_COUNT == 1) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end else begin
                state  <= S_TRAIN;
              end
            end
          end

          S_TRAIN: begin
            if (match) begin
              expected <= nxt;
              good     <= good + 4'd1;
              if (good + 4'd1 == LOCK_CNT4) begin
                state  <= S_LOCKED;
                locked <= 1'b1;
              end
            end else if (in_range) begin
              expected <= nxt;
              good     <= 4'd1;
            end else begin
              state <= S_UNLOCKED;
              good  <= '0;
            end
          end

          S_LOCKED: begin
            if (match) begin
              expected <= nxt;
            end else if (in_range) begin
              // Reseed from the new value; with a lock count of one we relock at once.
              expected <= nxt;
              good     <= 4'd1;
              if (LOCK_COUNT != 1) begin
                state  <= S_TRAIN;
                locked <= 1'b0;
              end
            end else begin
              state  <= S_UNLOCKED;
              locked <= 1'b0;
              good   <= '0;
            end
          end

          default: begin
            state  <= S_UNLOCKED;
            locked <= 1'b0;
            good   <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_counter_seq_checker.sv
// Bench for counter_seq_checker: a run-length reference model is compared every cycle,
// and directed sequences add hand-computed literal expectations.
module tb_counter_seq_checker;

  localparam int WIDTH      = 10;
  localparam int MODULUS    = 1000;
  localparam int LOCK_COUNT = 4;
  localparam int CNT_W      = 16;
  localparam int CMAX       = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             reset = 1'b0;
  logic [WIDTH-1:0] q_in = '0;
  logic             q_valid = 1'b0;
  logic             clear = 1'b0;
  logic             locked, err_pulse, wrap_pulse;
  logic [WIDTH-1:0] expected;
  logic [CNT_W-1:0] err_count, wrap_count;

  int n_checks = 0;
  int n_errors = 0;

  counter_seq_checker #(
    .WIDTH(WIDTH), .MODULUS(MODULUS), .LOCK_COUNT(LOCK_COUNT), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .q_in(q_in), .q_valid(q_valid), .clear(clear),
    .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse),
    .expected(expected), .err_count(err_count), .wrap_count(wrap_count)
  );

  always #5 clk = ~clk;

  // Reference model: lock means the last LOCK_COUNT valid in-range samples each followed
  // their predecessor; once locked, any sample other than the predicted one is an error.
  int m_run = 0;
  int m_locked = 0;
  int m_exp = 0;
  int m_err = 0;
  int m_wrap = 0;
  int m_errc = 0;
  int m_wrapc = 0;

  function automatic int succ(input int x);
    return (x == MODULUS - 1) ? 0 : x + 1;
  endfunction

  task automatic model_reset();
    m_run = 0; m_locked = 0; m_exp = 0; m_err = 0; m_wrap = 0; m_errc = 0; m_wrapc = 0;
  endtask

  always @(negedge reset) model_reset();

  always @(posedge clk) begin
    if (reset) begin
      int  v;
      bit  inr;
      bit  hit;
      v   = int'(q_in);
      inr = (v < MODULUS);
      hit = inr && (v == m_exp);
      m_err = 0;
      m_wrap = 0;
      if (q_valid) begin
        if (m_locked != 0) begin
          if (hit) begin
            m_exp = succ(v);
            if (v == MODULUS - 1) begin
              m_wrap = 1;
              m_wrapc = (m_wrapc < CMAX) ? m_wrapc + 1 : CMAX;
            end
          end else begin
            m_err = 1;
            m_errc = (m_errc < CMAX) ? m_errc + 1 : CMAX;
            if (inr) begin
              m_run = 1; m_exp = succ(v); m_locked = (LOCK_COUNT <= 1) ? 1 : 0;
            end else begin
              m_run = 0; m_locked = 0;
            end
          end
        end else if (inr) begin
          m_run = (hit && m_run > 0) ? m_run + 1 : 1;
          m_exp = succ(v);
          m_locked = (m_run >= LOCK_COUNT) ? 1 : 0;
        end else begin
          m_run = 0;
        end
      end
      if (clear) begin
        m_errc = 0; m_wrapc = 0;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    n_checks++;
    if (int'(locked) != m_locked || int'(err_pulse) != m_err || int'(wrap_pulse) != m_wrap ||
        int'(expected) != m_exp || int'(err_count) != m_errc || int'(wrap_count) != m_wrapc) begin
      n_errors++;
      $display("FAIL model t=%0t dut(lk=%0d ep=%0d wp=%0d exp=%0d ec=%0d wc=%0d) want(lk=%0d ep=%0d wp=%0d exp=%0d ec=%0d wc=%0d)",
               $time, locked, err_pulse, wrap_pulse, expected, err_count, wrap_count,
               m_locked, m_err, m_wrap, m_exp, m_errc, m_wrapc);
    end
  end

  task automatic chk(input string name, input int act, input int want);
    n_checks++;
    if (act != want) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, want);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; outputs seen right after this call
  // reflect the sample driven by the previous call.
  task automatic step(input int v, input bit vld, input bit clr);
    @(negedge clk);
    q_in    = WIDTH'(v);
    q_valid = vld;
    clear   = clr;
  endtask

  task automatic samp(input int v);
    step(v, 1'b1, 1'b0);
  endtask

  task automatic idle();
    step(0, 1'b0, 1'b0);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_locked"}, int'(locked), 0);
    chk({tag, "_err_pulse"}, int'(err_pulse), 0);
    chk({tag, "_wrap_pulse"}, int'(wrap_pulse), 0);
    chk({tag, "_expected"}, int'(expected), 0);
    chk({tag, "_err_count"}, int'(err_count), 0);
    chk({tag, "_wrap_count"}, int'(wrap_count), 0);
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    #2 reset = 1'b1;

    // Lock on 0..3
    samp(0); samp(1); samp(2); samp(3);
    chk("lock_before_last", int'(locked), 0);
    idle();
    chk("lock_locked", int'(locked), 1);
    chk("lock_expected", int'(expected), 4);
    chk("lock_err_count", int'(err_count), 0);
    chk("lock_model_exp", m_exp, 4);

    // Run up to the wrap point, then 997,998,999,0,1
    for (int v = 4; v <= 996; v++) samp(v);
    samp(997); samp(998); samp(999);
    samp(0);
    chk("wrap_pulse_at_999", int'(wrap_pulse), 1);
    samp(1);
    chk("wrap_pulse_after", int'(wrap_pulse), 0);
    idle();
    chk("wrap_count", int'(wrap_count), 1);
    chk("wrap_expected", int'(expected), 2);
    chk("wrap_err_count", int'(err_count), 0);

    // Glitch: expected=42, feed 500..503
    for (int v = 2; v <= 41; v++) samp(v);
    chk("glitch_pre_exp", int'(expected), 41);
    samp(500);
    samp(501);
    chk("glitch_err_pulse", int'(err_pulse), 1);
    chk("glitch_unlocked", int'(locked), 0);
    samp(502);
    chk("glitch_pulse_once", int'(err_pulse), 0);
    samp(503);
    chk("glitch_still_unlocked", int'(locked), 0);
    idle();
    chk("glitch_relocked", int'(locked), 1);
    chk("glitch_expected", int'(expected), 504);
    chk("glitch_err_count", int'(err_count), 1);

    // Upstream counter reset at expected=700 (clear stats on the last in-sequence sample)
    for (int v = 504; v <= 698; v++) samp(v);
    step(699, 1'b1, 1'b1);
    samp(0);
    chk("upst_cleared", int'(err_count), 0);
    chk("upst_expected_700", int'(expected), 700);
    samp(1); samp(2); samp(3);
    idle();
    chk("upst_err_count", int'(err_count), 1);
    chk("upst_locked", int'(locked), 1);
    chk("upst_expected", int'(expected), 4);

    // Out-of-range while locked with expected=0
    for (int v = 4; v <= 999; v++) samp(v);
    samp(1000);
    chk("oor_pre_exp", int'(expected), 0);
    samp(1023);
    chk("oor_err_pulse", int'(err_pulse), 1);
    chk("oor_unlocked", int'(locked), 0);
    samp(1000);
    chk("oor_no_second_pulse", int'(err_pulse), 0);
    idle();
    chk("oor_expected_held", int'(expected), 0);
    chk("oor_err_count", int'(err_count), 2);
    chk("oor_still_unlocked", int'(locked), 0);
    samp(5); samp(6); samp(7); samp(8);
    idle();
    chk("oor_relock", int'(locked), 1);
    chk("oor_relock_exp", int'(expected), 9);

    // Gaps of 3 invalid cycles between 10 and 11, then clear with a mismatch
    samp(9); samp(10);
    idle(); idle(); idle();
    chk("gap_exp_held", int'(expected), 11);
    samp(11); samp(12);
    idle();
    chk("gap_locked", int'(locked), 1);
    chk("gap_err_count", int'(err_count), 2);
    step(99, 1'b1, 1'b1);
    idle();
    chk("clr_err_pulse", int'(err_pulse), 1);
    chk("clr_err_count", int'(err_count), 0);

    // Build err_count=5, relock, then async reset between edges
    for (int k = 0; k < 5; k++) begin
      for (int i = 0; i < 4; i++) samp(200 + k * 100 + i);
      samp(250 + k * 100);
    end
    samp(0); samp(1); samp(2); samp(3);
    idle();
    chk("pre_rst_err_count", int'(err_count), 5);
    chk("pre_rst_locked", int'(locked), 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_all_zero("async_rst");
    @(negedge clk);
    #2 reset = 1'b1;
    samp(0); samp(1); samp(2); samp(3);
    idle();
    chk("post_rst_locked", int'(locked), 1);
    chk("post_rst_expected", int'(expected), 4);
    chk("post_rst_err_count", int'(err_count), 0);
    idle();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
